writeback_unit: RTL and testbench

- Final stage of the dual-lane pipeline; the producer end of the decode stage's forwarding interface.
- Each cycle it accepts up to two results from the execute lanes and commits them to the 8×16 architectural register file.
- It drives the two 19-bit forwarding buses `rd_val1`/`rd_val2` (`{value[15:0], rd[2:0]}`) consumed by decode, and exposes two bypassed read ports.
- It keeps a sticky halt flag and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/regfile_2w2r.sv | 45 ++++
 rtl/writeback_unit.sv | 95 +++++++++
 tb/tb_writeback_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the dual-lane pipeline: widths, halt opcode and the
// forwarding-slot layout that decode unpacks.
package cpu_pkg;

  localparam int          XLEN    = 16;
  localparam int          NREG    = 8;
  localparam int          REG_W   = 3;
  localparam logic [3:0]  HALT_OP = 4'hF;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [REG_W-1:0] rd;
  } fwd_t;

  localparam fwd_t FWD_IDLE = '0;

endpackage

// File: rtl/regfile_2w2r.sv
// Architectural register file: two write ports (port 1 wins on a shared
// address), two read ports that bypass same-cycle writes, r0 reads as zero.
module regfile_2w2r #(
  parameter int NREG  = 8,
  parameter int XLEN  = 16,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_we0,
  input  logic [REG_W-1:0] i_wa0,
  input  logic [XLEN-1:0]  i_wd0,
  input  logic             i_we1,
  input  logic [REG_W-1:0] i_wa1,
  input  logic [XLEN-1:0]  i_wd1,
  input  logic [REG_W-1:0] i_ra_a,
  input  logic [REG_W-1:0] i_ra_b,
  output logic [XLEN-1:0]  o_rd_a,
  output logic [XLEN-1:0]  o_rd_b
);

  logic [XLEN-1:0] r_mem [NREG];

  // NOTE: the array is cleared on reset because reset must leave every
  // architectural register at zero; this keeps it out of plain RAM macros.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (i_we1 && i_wa1 == REG_W'(i))      r_mem[i] <= i_wd1;
        else if (i_we0 && i_wa0 == REG_W'(i)) r_mem[i] <= i_wd0;
      end
    end
  end

  assign o_rd_a = (i_ra_a == '0)                 ? '0    :
                  (i_we1 && i_wa1 == i_ra_a)     ? i_wd1 :
                  (i_we0 && i_wa0 == i_ra_a)     ? i_wd0 : r_mem[i_ra_a];

  assign o_rd_b = (i_ra_b == '0)                 ? '0    :
                  (i_we1 && i_wa1 == i_ra_b)     ? i_wd1 :
                  (i_we0 && i_wa0 == i_ra_b)     ? i_wd0 : r_mem[i_ra_b];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: commits up to two lane results per cycle, drives the
// registered forwarding slots, and tracks the sticky halt and retired count.
module writeback_unit
  import cpu_pkg::*;
#(
  parameter int         NREG    = cpu_pkg::NREG,
  parameter int         XLEN    = cpu_pkg::XLEN,
  parameter logic [3:0] HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      l0_valid,
  input  logic                      l0_wen,
  input  logic [$clog2(NREG)-1:0]   l0_rd,
  input  logic [XLEN-1:0]           l0_value,
  input  logic [3:0]                l0_opcode,
  input  logic                      l1_valid,
  input  logic                      l1_wen,
  input  logic [$clog2(NREG)-1:0]   l1_rd,
  input  logic [XLEN-1:0]           l1_value,
  input  logic [3:0]                l1_opcode,
  input  logic [$clog2(NREG)-1:0]   rd_addr_a,
  input  logic [$clog2(NREG)-1:0]   rd_addr_b,
  output logic [XLEN-1:0]           rd_data_a,
  output logic [XLEN-1:0]           rd_data_b,
  output logic [$bits(fwd_t)-1:0]   rd_val1,
  output logic [$bits(fwd_t)-1:0]   rd_val2,
  output logic                      halted,
  output logic [XLEN-1:0]           retired
);

  localparam int RW = $clog2(NREG);

  logic            r_halted;
  logic [XLEN-1:0] r_retired;
  fwd_t            r_fwd0;
  fwd_t            r_fwd1;

  logic            w_commit0, w_commit1;
  logic            w_halt0, w_halt1;
  logic            w_we0, w_we1;
  logic [XLEN-1:0] w_inc;

  // Lane inputs are ignored while reset is asserted, and a halting lane 0
  // squashes the younger lane 1 in the same cycle.
  assign w_commit0 = l0_valid && !r_halted && !reset;
  assign w_halt0   = w_commit0 && (l0_opcode == HALT_OP);
  assign w_commit1 = l1_valid && !r_halted && !reset && !w_halt0;
  assign w_halt1   = w_commit1 && (l1_opcode == HALT_OP);

  assign w_we0 = w_commit0 && l0_wen && (l0_rd != '0);
  assign w_we1 = w_commit1 && l1_wen && (l1_rd != '0);
  assign w_inc = XLEN'(w_commit0) + XLEN'(w_commit1);

  regfile_2w2r #(
    .NREG  (NREG),
    .XLEN  (XLEN),
    .REG_W (RW)
  ) u_regfile (
    .clk     (clk),
    .i_reset (reset),
    .i_we0   (w_we0),
    .i_wa0   (l0_rd),
    .i_wd0   (l0_value),
    .i_we1   (w_we1),
    .i_wa1   (l1_rd),
    .i_wd1   (l1_value),
    .i_ra_a  (rd_addr_a),
    .i_ra_b  (rd_addr_b),
    .o_rd_a  (rd_data_a),
    .o_rd_b  (rd_data_b)
  );

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted  <= 1'b0;
      r_retired <= '0;
      r_fwd0    <= FWD_IDLE;
      r_fwd1    <= FWD_IDLE;
    end else begin
      r_halted  <= r_halted || w_halt0 || w_halt1;
      r_retired <= r_retired + w_inc;
      r_fwd0    <= w_we0 ? fwd_t'{value: l0_value, rd: l0_rd} : FWD_IDLE;
      r_fwd1    <= w_we1 ? fwd_t'{value: l1_value, rd: l1_rd} : FWD_IDLE;
    end
  end

  assign rd_val1 = r_fwd0;
  assign rd_val2 = r_fwd1;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, commit, conflict, r0, halt and
// counter-wrap scenarios with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        l0_valid, l0_wen, l1_valid, l1_wen;
  logic [2:0]  l0_rd, l1_rd, rd_addr_a, rd_addr_b;
  logic [15:0] l0_value, l1_value;
  logic [3:0]  l0_opcode, l1_opcode;
  logic [15:0] rd_data_a, rd_data_b, retired;
  logic [18:0] rd_val1, rd_val2;
  logic        halted;

  int total = 0;
  int bad   = 0;

  writeback_unit dut (
    .clk       (clk),
    .reset     (reset),
    .l0_valid  (l0_valid),
    .l0_wen    (l0_wen),
    .l0_rd     (l0_rd),
    .l0_value  (l0_value),
    .l0_opcode (l0_opcode),
    .l1_valid  (l1_valid),
    .l1_wen    (l1_wen),
    .l1_rd     (l1_rd),
    .l1_value  (l1_value),
    .l1_opcode (l1_opcode),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_val1   (rd_val1),
    .rd_val2   (rd_val2),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_l0(input logic v, input logic w, input logic [2:0] rd,
                        input logic [15:0] val, input logic [3:0] op);
    l0_valid = v; l0_wen = w; l0_rd = rd; l0_value = val; l0_opcode = op;
  endtask

  task automatic set_l1(input logic v, input logic w, input logic [2:0] rd,
                        input logic [15:0] val, input logic [3:0] op);
    l1_valid = v; l1_wen = w; l1_rd = rd; l1_value = val; l1_opcode = op;
  endtask

  task automatic idle_lanes();
    set_l0(1'b0, 1'b0, 3'd0, 16'h0, 4'h0);
    set_l1(1'b0, 1'b0, 3'd0, 16'h0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_l0(1'b1, 1'b1, 3'd3, 16'h9999, 4'h0);
    set_l1(1'b1, 1'b1, 3'd4, 16'h8888, 4'hF);
    rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    tick();
    tick();
    total++;
    if (rd_data_a !== 16'h0) begin
      bad++; $display("FAIL reset_bypass_ignored got=%h want=%h", rd_data_a, 16'h0);
    end
    reset = 1'b0;
    idle_lanes();
    #1;
    total++;
    if (rd_val1 !== 19'h0) begin bad++; $display("FAIL reset_rd_val1 got=%h want=%h", rd_val1, 19'h0); end
    total++;
    if (rd_val2 !== 19'h0) begin bad++; $display("FAIL reset_rd_val2 got=%h want=%h", rd_val2, 19'h0); end
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=%b", halted, 1'b0); end
    total++;
    if (retired !== 16'h0) begin bad++; $display("FAIL reset_retired got=%h want=%h", retired, 16'h0); end
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL reset_r3 got=%h want=%h", rd_data_a, 16'h0); end
    total++;
    if (rd_data_b !== 16'h0) begin bad++; $display("FAIL reset_r4 got=%h want=%h", rd_data_b, 16'h0); end
  endtask

  task automatic test_single_write();
    set_l0(1'b1, 1'b1, 3'd3, 16'h1234, 4'h0);
    tick();
    idle_lanes();
    rd_addr_a = 3'd3;
    #1;
    total++;
    if (rd_val1 !== {16'h1234, 3'd3}) begin bad++; $display("FAIL single_rd_val1 got=%h want=%h", rd_val1, {16'h1234, 3'd3}); end
    total++;
    if (rd_val2 !== 19'h0) begin bad++; $display("FAIL single_rd_val2 got=%h want=%h", rd_val2, 19'h0); end
    total++;
    if (retired !== 16'd1) begin bad++; $display("FAIL single_retired got=%h want=%h", retired, 16'd1); end
    tick();
    total++;
    if (rd_val1 !== 19'h0) begin bad++; $display("FAIL single_rd_val1_idle got=%h want=%h", rd_val1, 19'h0); end
    total++;
    if (rd_data_a !== 16'h1234) begin bad++; $display("FAIL single_r3 got=%h want=%h", rd_data_a, 16'h1234); end
  endtask

  task automatic test_conflict();
    set_l0(1'b1, 1'b1, 3'd5, 16'hAAAA, 4'h0);
    set_l1(1'b1, 1'b1, 3'd5, 16'h5555, 4'h0);
    rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    #1;
    total++;
    if (rd_data_a !== 16'h5555) begin bad++; $display("FAIL conflict_bypass got=%h want=%h", rd_data_a, 16'h5555); end
    total++;
    if (rd_data_b !== 16'h1234) begin bad++; $display("FAIL conflict_other_port got=%h want=%h", rd_data_b, 16'h1234); end
    tick();
    idle_lanes();
    #1;
    total++;
    if (rd_val1 !== {16'hAAAA, 3'd5}) begin bad++; $display("FAIL conflict_rd_val1 got=%h want=%h", rd_val1, {16'hAAAA, 3'd5}); end
    total++;
    if (rd_val2 !== {16'h5555, 3'd5}) begin bad++; $display("FAIL conflict_rd_val2 got=%h want=%h", rd_val2, {16'h5555, 3'd5}); end
    total++;
    if (retired !== 16'd3) begin bad++; $display("FAIL conflict_retired got=%h want=%h", retired, 16'd3); end
    total++;
    if (rd_data_a !== 16'h5555) begin bad++; $display("FAIL conflict_r5 got=%h want=%h", rd_data_a, 16'h5555); end
  endtask

  task automatic test_r0_write();
    set_l1(1'b1, 1'b1, 3'd0, 16'hFFFF, 4'h0);
    rd_addr_a = 3'd0;
    #1;
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL r0_bypass got=%h want=%h", rd_data_a, 16'h0); end
    tick();
    idle_lanes();
    #1;
    total++;
    if (rd_val2 !== 19'h0) begin bad++; $display("FAIL r0_rd_val2 got=%h want=%h", rd_val2, 19'h0); end
    total++;
    if (retired !== 16'd4) begin bad++; $display("FAIL r0_retired got=%h want=%h", retired, 16'd4); end
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL r0_read got=%h want=%h", rd_data_a, 16'h0); end
  endtask

  task automatic test_no_wen();
    set_l0(1'b1, 1'b0, 3'd6, 16'h6666, 4'h0);
    rd_addr_a = 3'd6;
    #1;
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL nowen_bypass got=%h want=%h", rd_data_a, 16'h0); end
    tick();
    idle_lanes();
    #1;
    total++;
    if (rd_val1 !== 19'h0) begin bad++; $display("FAIL nowen_rd_val1 got=%h want=%h", rd_val1, 19'h0); end
    total++;
    if (retired !== 16'd5) begin bad++; $display("FAIL nowen_retired got=%h want=%h", retired, 16'd5); end
  endtask

  task automatic test_lane0_halt();
    set_l1(1'b1, 1'b1, 3'd2, 16'h0022, 4'h0);
    tick();
    set_l0(1'b1, 1'b1, 3'd1, 16'h0101, 4'hF);
    set_l1(1'b1, 1'b1, 3'd2, 16'h0007, 4'h0);
    rd_addr_a = 3'd2; rd_addr_b = 3'd1;
    #1;
    total++;
    if (rd_data_a !== 16'h0022) begin bad++; $display("FAIL halt0_squashed_bypass got=%h want=%h", rd_data_a, 16'h0022); end
    tick();
    idle_lanes();
    #1;
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt0_halted got=%b want=%b", halted, 1'b1); end
    total++;
    if (retired !== 16'd7) begin bad++; $display("FAIL halt0_retired got=%h want=%h", retired, 16'd7); end
    total++;
    if (rd_val1 !== {16'h0101, 3'd1}) begin bad++; $display("FAIL halt0_rd_val1 got=%h want=%h", rd_val1, {16'h0101, 3'd1}); end
    total++;
    if (rd_val2 !== 19'h0) begin bad++; $display("FAIL halt0_rd_val2 got=%h want=%h", rd_val2, 19'h0); end
    total++;
    if (rd_data_a !== 16'h0022) begin bad++; $display("FAIL halt0_r2 got=%h want=%h", rd_data_a, 16'h0022); end
    total++;
    if (rd_data_b !== 16'h0101) begin bad++; $display("FAIL halt0_r1 got=%h want=%h", rd_data_b, 16'h0101); end
    set_l0(1'b1, 1'b1, 3'd4, 16'h4444, 4'h0);
    set_l1(1'b1, 1'b1, 3'd6, 16'h6666, 4'h0);
    rd_addr_a = 3'd4; rd_addr_b = 3'd6;
    tick();
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL halted_bypass got=%h want=%h", rd_data_a, 16'h0); end
    idle_lanes();
    #1;
    total++;
    if (retired !== 16'd7) begin bad++; $display("FAIL halted_retired got=%h want=%h", retired, 16'd7); end
    total++;
    if (rd_val1 !== 19'h0) begin bad++; $display("FAIL halted_rd_val1 got=%h want=%h", rd_val1, 19'h0); end
    total++;
    if (rd_data_a !== 16'h0) begin bad++; $display("FAIL halted_r4 got=%h want=%h", rd_data_a, 16'h0); end
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halted_sticky got=%b want=%b", halted, 1'b1); end
  endtask

  task automatic test_lane1_halt();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL rehalt_cleared got=%b want=%b", halted, 1'b0); end
    set_l0(1'b1, 1'b1, 3'd3, 16'h3333, 4'h0);
    set_l1(1'b1, 1'b1, 3'd4, 16'h4444, 4'hF);
    tick();
    idle_lanes();
    rd_addr_a = 3'd4; rd_addr_b = 3'd3;
    #1;
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt1_halted got=%b want=%b", halted, 1'b1); end
    total++;
    if (retired !== 16'd2) begin bad++; $display("FAIL halt1_retired got=%h want=%h", retired, 16'd2); end
    total++;
    if (rd_val1 !== {16'h3333, 3'd3}) begin bad++; $display("FAIL halt1_rd_val1 got=%h want=%h", rd_val1, {16'h3333, 3'd3}); end
    total++;
    if (rd_val2 !== {16'h4444, 3'd4}) begin bad++; $display("FAIL halt1_rd_val2 got=%h want=%h", rd_val2, {16'h4444, 3'd4}); end
    total++;
    if (rd_data_a !== 16'h4444) begin bad++; $display("FAIL halt1_r4 got=%h want=%h", rd_data_a, 16'h4444); end
    total++;
    if (rd_data_b !== 16'h3333) begin bad++; $display("FAIL halt1_r3 got=%h want=%h", rd_data_b, 16'h3333); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_l0(1'b1, 1'b0, 3'd0, 16'h0, 4'h0);
    set_l1(1'b1, 1'b0, 3'd0, 16'h0, 4'h0);
    for (int i = 0; i < 32767; i++) tick();
    set_l1(1'b0, 1'b0, 3'd0, 16'h0, 4'h0);
    tick();
    total++;
    if (retired !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=%h", retired, 16'hFFFF); end
    set_l1(1'b1, 1'b0, 3'd0, 16'h0, 4'h0);
    tick();
    idle_lanes();
    #1;
    total++;
    if (retired !== 16'h0001) begin bad++; $display("FAIL wrap_dual got=%h want=%h", retired, 16'h0001); end
  endtask

  initial begin
    reset = 1'b1;
    idle_lanes();
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    test_reset();
    test_single_write();
    test_conflict();
    test_r0_write();
    test_no_wen();
    test_lane0_halt();
    test_lane1_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
